alarma_controller: RTL and testbench



---
 rtl/alarma_controller_pkg.sv | 10 +
 rtl/alarma_controller_if.sv | 14 +
 rtl/alarma_timer.sv | 17 +
 rtl/alarma_controller.sv | 59 +++++
 tb/tb_alarma_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alarma_controller_pkg.sv
// alarma_controller_pkg: state codes and datapath widths shared by the alarm controller slice
package alarma_controller_pkg;
  localparam int ST_W  = 3;
  localparam int TMR_W = 8;
  localparam logic [ST_W-1:0] ST_DISARMED = 3'd0;
  localparam logic [ST_W-1:0] ST_EXIT     = 3'd1;
  localparam logic [ST_W-1:0] ST_ARMED    = 3'd2;
  localparam logic [ST_W-1:0] ST_ENTRY    = 3'd3;
  localparam logic [ST_W-1:0] ST_ALARM    = 3'd4;
endpackage

// File: rtl/alarma_controller_if.sv
// alarma_controller_if: panel/sensor inputs and siren/indicator outputs of the alarm controller
interface alarma_controller_if;
  import alarma_controller_pkg::*;
  logic            arm;
  logic            disarm;
  logic [3:0]      code;
  logic            sensor_y;
  logic            siren;
  logic            armed;
  logic            beep;
  logic [ST_W-1:0] state;
  modport master (output arm, disarm, code, sensor_y, input siren, armed, beep, state);
  modport slave  (input arm, disarm, code, sensor_y, output siren, armed, beep, state);
endinterface

// File: rtl/alarma_timer.sv
// alarma_timer: loadable down-counter that stops at zero instead of wrapping
module alarma_timer
  import alarma_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/alarma_controller.sv
// alarma_controller: arm/exit/entry/siren sequencing with PIN disarm and three-strike lockout
module alarma_controller
  import alarma_controller_pkg::*;
#(
  parameter int         EXIT_CYC  = 8,
  parameter int         ENTRY_CYC = 4,
  parameter int         SIREN_CYC = 16,
  parameter logic [3:0] PIN       = 4'b1010
) (
  input logic           clk,
  input logic           reset,
  alarma_controller_if.slave bus
);
  localparam logic [TMR_W-1:0] EXIT_LD  = TMR_W'(EXIT_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LD = TMR_W'(ENTRY_CYC - 1);
  localparam logic [TMR_W-1:0] SIREN_LD = TMR_W'(SIREN_CYC - 1);
  logic [ST_W-1:0]  st, nxt;
  logic [1:0]       fail_cnt;
  logic [TMR_W-1:0] lv;
  logic             ld, zero, good, bad_code, strike3;
  assign good     = bus.disarm && bus.code == PIN;
  assign bad_code = bus.disarm && bus.code != PIN;
  assign strike3  = bad_code && fail_cnt == 2'd2;
  always_comb begin
    nxt = st;
    ld  = 1'b0;
    lv  = '0;
    if (st == ST_DISARMED) begin
      if (bus.arm) begin nxt = ST_EXIT; ld = 1'b1; lv = EXIT_LD; end
    end else if (st > ST_ALARM || good) nxt = ST_DISARMED;
    // a strike while already sounding leaves the running burst untouched
    else if (strike3 && st != ST_ALARM) begin nxt = ST_ALARM; ld = 1'b1; lv = SIREN_LD; end
    else case (st)
      ST_EXIT:  if (zero) nxt = ST_ARMED;
      ST_ARMED: if (bus.sensor_y) begin nxt = ST_ENTRY; ld = 1'b1; lv = ENTRY_LD; end
      ST_ENTRY: if (zero) begin nxt = ST_ALARM; ld = 1'b1; lv = SIREN_LD; end
      ST_ALARM: if (zero) begin
        nxt = bus.sensor_y ? ST_ALARM : ST_ARMED;
        ld  = bus.sensor_y;
        lv  = SIREN_LD;
      end
      default: nxt = ST_DISARMED;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st       <= ST_DISARMED;
      fail_cnt <= '0;
    end else begin
      st <= nxt;
      if (nxt == ST_DISARMED) fail_cnt <= '0;
      else if (bad_code && st != ST_DISARMED && fail_cnt != 2'd3) fail_cnt <= fail_cnt + 1'b1;
    end
  alarma_timer u_timer (.clk(clk), .reset(reset), .load(ld), .load_val(lv), .zero(zero));
  assign bus.state = st;
  assign bus.siren = st == ST_ALARM;
  assign bus.armed = st != ST_DISARMED && st <= ST_ALARM;
  assign bus.beep  = st == ST_EXIT || st == ST_ENTRY;
endmodule

// File: tb/tb_alarma_controller.sv
// tb_alarma_controller: directed scenario tests for the alarm sequencing controller
module tb_alarma_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  alarma_controller_if b();
  alarma_controller dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.arm = 1'b0; b.disarm = 1'b0; b.code = 4'b0000; b.sensor_y = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    total++;
    if ({b.state, b.siren, b.armed, b.beep} !== 6'b000_000) begin
      bad++; $display("FAIL reset_outputs got st=%0d s=%b a=%b bp=%b exp st=0 s=0 a=0 bp=0", b.state, b.siren, b.armed, b.beep);
    end
    reset = 1'b0;
    tick();
    total++;
    if (b.state !== 3'd0) begin bad++; $display("FAIL reset_idle got=%0d exp=0", b.state); end
  endtask

  task automatic test_arm_exit();
    b.arm = 1'b1;
    tick();
    b.arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (b.state !== 3'd1 || b.beep !== 1'b1 || b.armed !== 1'b1) begin
        bad++; $display("FAIL exit_cycle%0d got st=%0d bp=%b a=%b exp st=1 bp=1 a=1", i, b.state, b.beep, b.armed);
      end
      tick();
    end
    total++;
    if (b.state !== 3'd2 || b.armed !== 1'b1 || b.beep !== 1'b0) begin
      bad++; $display("FAIL exit_to_armed got st=%0d a=%b bp=%b exp st=2 a=1 bp=0", b.state, b.armed, b.beep);
    end
  endtask

  task automatic test_entry_alarm();
    b.sensor_y = 1'b1;
    tick();
    b.sensor_y = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (b.state !== 3'd3 || b.beep !== 1'b1 || b.siren !== 1'b0) begin
        bad++; $display("FAIL entry_cycle%0d got st=%0d bp=%b s=%b exp st=3 bp=1 s=0", i, b.state, b.beep, b.siren);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (b.state !== 3'd4 || b.siren !== 1'b1 || b.beep !== 1'b0) begin
        bad++; $display("FAIL siren_cycle%0d got st=%0d s=%b bp=%b exp st=4 s=1 bp=0", i, b.state, b.siren, b.beep);
      end
      tick();
    end
    total++;
    if (b.state !== 3'd2 || b.siren !== 1'b0) begin
      bad++; $display("FAIL siren_end got st=%0d s=%b exp st=2 s=0", b.state, b.siren);
    end
  endtask

  task automatic test_good_last_entry();
    b.sensor_y = 1'b1;
    tick();
    b.sensor_y = 1'b0;
    tick(); tick(); tick();
    total++;
    if (b.state !== 3'd3) begin bad++; $display("FAIL entry_last got=%0d exp=3", b.state); end
    b.disarm = 1'b1; b.code = 4'b1010;
    tick();
    b.disarm = 1'b0; b.code = 4'b0000;
    total++;
    if ({b.state, b.siren, b.armed, b.beep} !== 6'b000_000) begin
      bad++; $display("FAIL good_beats_expiry got st=%0d s=%b a=%b bp=%b exp all 0", b.state, b.siren, b.armed, b.beep);
    end
    tick();
    total++;
    if (b.state !== 3'd0 || b.siren !== 1'b0) begin
      bad++; $display("FAIL good_stays got st=%0d s=%b exp st=0 s=0", b.state, b.siren);
    end
  endtask

  task automatic arm_to_armed();
    b.arm = 1'b1;
    tick();
    b.arm = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_fail_codes();
    for (int r = 0; r < 2; r++) begin
      arm_to_armed();
      total++;
      if (b.state !== 3'd2) begin bad++; $display("FAIL fail_armed r%0d got=%0d exp=2", r, b.state); end
      b.disarm = 1'b1; b.code = 4'b0000;
      for (int i = 1; i <= 3; i++) begin
        tick();
        total++;
        if (b.state !== (i == 3 ? 3'd4 : 3'd2)) begin
          bad++; $display("FAIL bad_code r%0d n%0d got=%0d exp=%0d", r, i, b.state, (i == 3 ? 4 : 2));
        end
      end
      b.code = 4'b1010;
      tick();
      b.disarm = 1'b0; b.code = 4'b0000;
      total++;
      if (b.state !== 3'd0 || b.siren !== 1'b0) begin
        bad++; $display("FAIL good_after_lockout r%0d got st=%0d s=%b exp st=0 s=0", r, b.state, b.siren);
      end
    end
    arm_to_armed();
    b.disarm = 1'b1; b.code = 4'b0110;
    tick();
    b.disarm = 1'b0;
    tick();
    total++;
    if (b.state !== 3'd2) begin bad++; $display("FAIL fresh_single_bad got=%0d exp=2", b.state); end
    b.disarm = 1'b1; b.code = 4'b1010;
    tick();
    b.disarm = 1'b0; b.code = 4'b0000;
    total++;
    if (b.state !== 3'd0) begin bad++; $display("FAIL fresh_disarm got=%0d exp=0", b.state); end
  endtask

  task automatic test_siren_hold_reset();
    arm_to_armed();
    b.sensor_y = 1'b1;
    tick();
    repeat (4) tick();
    for (int i = 0; i < 40; i++) begin
      total++;
      if (b.state !== 3'd4 || b.siren !== 1'b1) begin
        bad++; $display("FAIL hold_siren cycle%0d got st=%0d s=%b exp st=4 s=1", i, b.state, b.siren);
      end
      tick();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (b.state !== 3'd0 || b.siren !== 1'b0 || b.armed !== 1'b0) begin
      bad++; $display("FAIL async_reset got st=%0d s=%b a=%b exp st=0 s=0 a=0", b.state, b.siren, b.armed);
    end
    b.sensor_y = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_arm_disarm_same();
    b.arm = 1'b1; b.disarm = 1'b1; b.code = 4'b1010;
    tick();
    b.arm = 1'b0; b.disarm = 1'b0; b.code = 4'b0000;
    b.sensor_y = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (b.state !== 3'd1) begin bad++; $display("FAIL arm_wins_exit%0d got=%0d exp=1", i, b.state); end
      tick();
    end
    b.sensor_y = 1'b0;
    total++;
    if (b.state !== 3'd2) begin bad++; $display("FAIL exit_ignores_sensor got=%0d exp=2", b.state); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arm_exit();
    test_entry_alarm();
    test_good_last_entry();
    test_fail_codes();
    test_siren_hold_reset();
    test_arm_disarm_same();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
